// File: rtl/vortex_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vortex_launch_ctrl
// Purpose  : Host-driven Vortex kernel launch sequencer (reset window, busy
//            handshake, run timing, sticky completion/timeout/abort status).
// Options  : VX_LAUNCH_TIMEOUT_EN - honour timeout_limit during RUN.
// Revision : 1.0 - initial release
// ============================================================================
module vortex_launch_ctrl #(
  parameter int RESET_CYCLES     = 8,
  parameter int BUSY_WAIT_CYCLES = 64,
  parameter int PC_WIDTH         = 32,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_pc,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] timeout_limit,
  input  logic                 Vortex_busy,
  output logic                 Vortex_reset,
  output logic [PC_WIDTH-1:0]  Vortex_PC_reset_val,
  output logic                 host_mem_lock,
  output logic                 running,
  output logic                 done_pulse,
  output logic                 status_done,
  output logic                 status_timeout,
  output logic                 status_abort,
  output logic                 start_ignored,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4,
    S_ABORT     = 3'd5
  } state_t;

  localparam int c_TIMER_MAX = (RESET_CYCLES > BUSY_WAIT_CYCLES) ? RESET_CYCLES : BUSY_WAIT_CYCLES;
  localparam int c_TW        = $clog2(c_TIMER_MAX + 1);

  localparam logic [c_TW-1:0]      c_RESET_LOAD = c_TW'(RESET_CYCLES - 1);
  localparam logic [c_TW-1:0]      c_WAIT_LOAD  = c_TW'(BUSY_WAIT_CYCLES - 1);
  localparam logic [c_TW-1:0]      c_TIMER_ONE  = c_TW'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX    = '1;

  state_t               r_state;
  logic [c_TW-1:0]      r_timer;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [PC_WIDTH-1:0]  r_pc;
  logic                 r_vx_reset;
  logic                 r_mem_lock;
  logic                 r_running;
  logic                 r_done_pulse;
  logic                 r_st_done;
  logic                 r_st_timeout;
  logic                 r_st_abort;
  logic                 r_start_ignored;

  state_t          w_next_state;
  logic [c_TW-1:0] w_next_timer;
  logic            w_accept;
  logic            w_timeout_hit;
  logic            w_set_done;
  logic            w_set_timeout;
  logic            w_set_abort;

`ifdef VX_LAUNCH_TIMEOUT_EN
  assign w_timeout_hit = (timeout_limit != '0) && (r_cycle_count == (timeout_limit - c_CNT_ONE));
`else
  logic w_unused_timeout_limit;
  assign w_unused_timeout_limit = ^timeout_limit;
  assign w_timeout_hit          = 1'b0;
`endif

  // abort has priority over every other event in the active states
  always_comb begin
    w_next_state  = r_state;
    w_next_timer  = r_timer;
    w_accept      = 1'b0;
    w_set_done    = 1'b0;
    w_set_timeout = 1'b0;
    w_set_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept     = 1'b1;
          w_next_state = S_RESET;
          w_next_timer = c_RESET_LOAD;
        end
      end
      S_RESET: begin
        if (abort) begin
          w_set_abort  = 1'b1;
          w_next_state = S_ABORT;
          w_next_timer = c_RESET_LOAD;
        end else if (r_timer == '0) begin
          w_next_state = S_WAIT_BUSY;
          w_next_timer = c_WAIT_LOAD;
        end else begin
          w_next_timer = r_timer - c_TIMER_ONE;
        end
      end
      S_WAIT_BUSY: begin
        if (abort || (!Vortex_busy && r_timer == '0)) begin
          w_set_abort  = 1'b1;
          w_next_state = S_ABORT;
          w_next_timer = c_RESET_LOAD;
        end else if (Vortex_busy) begin
          w_next_state = S_RUN;
        end else begin
          w_next_timer = r_timer - c_TIMER_ONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_set_abort  = 1'b1;
          w_next_state = S_ABORT;
          w_next_timer = c_RESET_LOAD;
        end else if (!Vortex_busy) begin
          w_set_done   = 1'b1;
          w_next_state = S_DONE;
        end else if (w_timeout_hit) begin
          w_set_timeout = 1'b1;
          w_next_state  = S_ABORT;
          w_next_timer  = c_RESET_LOAD;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      S_ABORT: begin
        if (r_timer == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_timer = r_timer - c_TIMER_ONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_cycle_count   <= '0;
      r_pc            <= '0;
      r_vx_reset      <= 1'b1;
      r_mem_lock      <= 1'b0;
      r_running       <= 1'b0;
      r_done_pulse    <= 1'b0;
      r_st_done       <= 1'b0;
      r_st_timeout    <= 1'b0;
      r_st_abort      <= 1'b0;
      r_start_ignored <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= w_next_timer;
      r_vx_reset   <= !(w_next_state inside {S_WAIT_BUSY, S_RUN});
      r_mem_lock   <= w_next_state inside {S_RESET, S_WAIT_BUSY, S_RUN, S_ABORT};
      r_running    <= w_next_state inside {S_RESET, S_WAIT_BUSY, S_RUN};
      // the pulse lands on DONE or on the last ABORT cycle
      r_done_pulse <= (w_next_state == S_DONE) ||
                      ((w_next_state == S_ABORT) && (w_next_timer == '0));

      if (w_accept) begin
        r_pc            <= start_pc;
        r_cycle_count   <= '0;
        r_st_done       <= 1'b0;
        r_st_timeout    <= 1'b0;
        r_st_abort      <= 1'b0;
        r_start_ignored <= 1'b0;
      end else begin
        if (r_state == S_RUN && r_cycle_count != c_CNT_MAX) begin
          r_cycle_count <= r_cycle_count + c_CNT_ONE;
        end
        if (w_set_done) begin
          r_st_done <= 1'b1;
        end
        if (w_set_timeout) begin
          r_st_timeout <= 1'b1;
        end
        if (w_set_abort) begin
          r_st_abort <= 1'b1;
        end
        if (start && r_state != S_IDLE) begin
          r_start_ignored <= 1'b1;
        end
      end
    end
  end

  assign Vortex_reset        = r_vx_reset;
  assign Vortex_PC_reset_val = r_pc;
  assign host_mem_lock       = r_mem_lock;
  assign running             = r_running;
  assign done_pulse          = r_done_pulse;
  assign status_done         = r_st_done;
  assign status_timeout      = r_st_timeout;
  assign status_abort        = r_st_abort;
  assign start_ignored       = r_start_ignored;
  assign cycle_count         = r_cycle_count;
  assign state               = r_state;

endmodule
`default_nettype wire
